fpmul_seq: RTL
==============

# fpmul_seq

Issue controller that shares one fixed-latency FPMul datapath (multiplier plus aux flag generator) between N_REQ requesters. Round-robin arbitration, one issue per cycle, credit-based flow control against per-requester response FIFOs. Sits between requester ports and the FPMul pipeline; the pipeline itself never stalls.

## Interface
- N_REQ, 2, number of requesters (2..4)
- LAT, 4, FPMul latency in cycles from mul_start to mul_result/mul_flags valid (≥1)
- DEPTH, 2, per-requester response FIFO depth (power of 2, ≥1)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  operation request per requester
- req_a, req_b  in  N_REQ*32  IEEE-754 single operands, requester i at [32i+31:32i]
- req_ready  out  N_REQ  grant; handshake when req_valid[i] & req_ready[i]
- mul_start  out  1  registered issue strobe to FPMul
- mul_a, mul_b  out  32  registered operands to FPMul
- mul_result  in  32  product, valid LAT cycles after mul_start
- mul_flags  in  12  FPMul flag bus, aligned with mul_result
- rsp_valid  out  N_REQ  response available
- rsp_result  out  N_REQ*32  product per requester
- rsp_flags  out  N_REQ*6  {unf, ovf, nan, inf, zero, dnf} per requester
- rsp_ready  in  N_REQ  response consumed when rsp_valid[i] & rsp_ready[i]
- busy  out  1  any op in flight or any FIFO non-empty

## Operation
- Credit counter per requester, width clog2(DEPTH+1), reset DEPTH. Eligible iff req_valid[i] & credit[i]≠0.
- Round-robin: search starts at last_grant+1 mod N_REQ; at most one req_ready high per cycle; req_ready may depend combinationally on req_valid. last_grant updates only on a handshake.
- Handshake: credit[i]−1; operands and id captured into issue register; tag pipeline (LAT stages of {valid, id}) shifts in {1, i}.
- Tag pipeline output valid: {mul_flags[5], mul_flags[4], mul_flags[3:0]} and mul_result pushed into FIFO[id]. FIFO can never overflow (credit guarantee); overflow is an assertion failure.
- Response pop: credit[i]+1. Same-cycle issue and pop on one requester: credit unchanged.
- Responses per requester return in issue order; requesters independent.
- Reset (any time, including mid-operation): in-flight ops discarded, FIFOs emptied, credits = DEPTH, last_grant = N_REQ−1 (requester 0 highest priority first).

## Timing
- Reset values: req_ready = 0 while in reset, mul_start = 0, mul_a = mul_b = 0, rsp_valid = 0, rsp_result = 0, rsp_flags = 0, busy = 0.
- Handshake cycle t → mul_start/mul_a/mul_b at t+1 → result captured at t+1+LAT → rsp_valid at t+2+LAT (latency LAT+2).
- Throughput: one issue per cycle across all requesters; one requester alone with rsp_ready held high sustains 1/cycle when DEPTH ≥ LAT+2, else DEPTH ops per LAT+2 cycles.
- rsp_* registered; rsp_valid stays high with stable data until popped.
- busy combinational OR of tag-pipeline valids, issue register and FIFO non-empty flags.

## Configuration
- FPMUL_SEQ_PERF_EN defined: adds outputs perf_issue (32 bit, handshakes) and perf_stall (32 bit, cycles with some req_valid high but no handshake); both wrap, reset 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- fpmul_pkg: flag bus index constants (NAN=3, INF=2, ZERO=1, DNF=0, OVF=4, UNF=5), rsp flag struct typedef, DATA_W=32, FLAG_W=12.
- Sub-module fpmul_rsp_fifo (parameter DEPTH, 38-bit entries, push/pop/empty/full), instantiated N_REQ times.

## Test plan
- Single op: req 0, a=0x3FC00000, b=0x40000000, FPMul model returns 0x40400000 flags 0 → rsp_valid[0] exactly LAT+2 cycles after handshake, result 0x40400000, flags 0.
- Contention: both requesters valid every cycle, rsp_ready high → grants alternate 0,1,0,1, each response in issue order, no drops.
- Backpressure: req 1 rsp_ready low, DEPTH=2 → exactly 2 handshakes, req_ready[1] then low; one pop → one further handshake accepted.
- Flag routing: model drives mul_flags=12'h008 (NaN) for req 1 op → rsp_flags[1] = 6'b001000; mul_flags=12'h010 → 6'b010000.
- Reset mid-flight: 3 ops in flight, pulse rst low → all rsp_valid 0, busy 0, credits DEPTH; stale results of discarded ops never appear.
- Simultaneous issue and pop on req 0 with credit 1 → credit stays 1 and next cycle still eligible.

Source files
------------

// File: rtl/fpmul_pkg.sv
// Shared constants and types for the FPMul issue controller.
package fpmul_pkg;
  localparam int DATA_W = 32;
  localparam int FLAG_W = 12;

  // Bit positions on the FPMul flag bus
  localparam int FL_DNF  = 0;
  localparam int FL_ZERO = 1;
  localparam int FL_INF  = 2;
  localparam int FL_NAN  = 3;
  localparam int FL_OVF  = 4;
  localparam int FL_UNF  = 5;

  typedef struct packed {
    logic unf;
    logic ovf;
    logic nan;
    logic inf;
    logic zero;
    logic dnf;
  } rsp_flags_t;

  typedef struct packed {
    rsp_flags_t        flags;
    logic [DATA_W-1:0] result;
  } rsp_t;

  localparam int RSP_W = $bits(rsp_t);
endpackage

// File: rtl/fpmul_rsp_fifo.sv
// Per-requester response FIFO. Head entry is read straight from the storage
// flops, so the output is registered and stays stable until popped.
module fpmul_rsp_fifo
  import fpmul_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = RSP_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign rd_data = mem_q[rd_ptr_q];

  // Next-state: write at tail, advance pointers with explicit wrap (DEPTH may be 1)
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!push && pop) cnt_d = cnt_q - CW'(1);
  end

  // Storage and pointer registers; reset clears contents so outputs read 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Credits must make overflow impossible
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));
endmodule

// File: rtl/fpmul_seq.sv
// Issue controller sharing one fixed-latency FPMul between N_REQ requesters.
// Round-robin grant, credit flow control against per-requester response FIFOs.
// Optional FPMUL_SEQ_PERF_EN adds perf_issue / perf_stall counters.
module fpmul_seq
  import fpmul_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int LAT   = 4,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    mul_start,
  output logic [DATA_W-1:0]       mul_a,
  output logic [DATA_W-1:0]       mul_b,
  input  logic [DATA_W-1:0]       mul_result,
  input  logic [FLAG_W-1:0]       mul_flags,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [N_REQ*DATA_W-1:0] rsp_result,
  output logic [N_REQ*6-1:0]      rsp_flags,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic                    busy
`ifdef FPMUL_SEQ_PERF_EN
  ,
  output logic [31:0]             perf_issue,
  output logic [31:0]             perf_stall
`endif
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(DEPTH + 1);

  logic [N_REQ-1:0][DATA_W-1:0] req_a_v, req_b_v, rsp_result_v;
  logic [N_REQ-1:0][5:0]        rsp_flags_v;
  logic [N_REQ-1:0][CW-1:0]     credit_q, credit_d;
  logic [N_REQ-1:0]             elig, grant, pop, push, empty, full;
  logic [IW-1:0]                last_grant_q, last_grant_d, hs_id;
  logic                         hs;
  // vld_pipe_q[0]/id_pipe_q[0] is the issue register; [LAT] lines up with mul_result
  logic [LAT:0]                 vld_pipe_q, vld_pipe_d;
  logic [LAT:0][IW-1:0]         id_pipe_q, id_pipe_d;
  logic [DATA_W-1:0]            mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  rsp_t                         push_rsp;
  rsp_t [N_REQ-1:0]             rsp_q;
  logic                         unused_flags;

  assign req_a_v      = req_a;
  assign req_b_v      = req_b;
  assign unused_flags = ^mul_flags[FLAG_W-1:6];

  // Round-robin pick among eligible requesters, starting after last grant
  always_comb begin
    hs    = 1'b0;
    hs_id = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      int idx;
      idx = (int'(last_grant_q) + k) % N_REQ;
      if (!hs && elig[idx]) begin
        hs    = 1'b1;
        hs_id = IW'(idx);
      end
    end
    grant = hs ? (N_REQ'(1) << hs_id) : '0;
  end

  // Eligibility, grant gating in reset, credit and issue next-state
  always_comb begin
    for (int i = 0; i < N_REQ; i++) elig[i] = req_valid[i] && (credit_q[i] != '0);
    req_ready = rst ? grant : '0;
    pop       = rsp_valid & rsp_ready;
    for (int i = 0; i < N_REQ; i++) begin
      credit_d[i] = credit_q[i];
      if (req_ready[i] && !pop[i])      credit_d[i] = credit_q[i] - CW'(1);
      else if (!req_ready[i] && pop[i]) credit_d[i] = credit_q[i] + CW'(1);
    end
    last_grant_d = hs ? hs_id : last_grant_q;
    vld_pipe_d   = {vld_pipe_q[LAT-1:0], hs};
    id_pipe_d    = {id_pipe_q[LAT-1:0], hs_id};
    mul_a_d      = hs ? req_a_v[hs_id] : mul_a_q;
    mul_b_d      = hs ? req_b_v[hs_id] : mul_b_q;
  end

  // Issue register, tag pipeline, credits and arbiter pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe_q   <= '0;
      id_pipe_q    <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      credit_q     <= {N_REQ{CW'(DEPTH)}};
      last_grant_q <= IW'(N_REQ - 1);
    end else begin
      vld_pipe_q   <= vld_pipe_d;
      id_pipe_q    <= id_pipe_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      credit_q     <= credit_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign mul_start = vld_pipe_q[0];
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;

  assign push_rsp.flags  = rsp_flags_t'(mul_flags[FL_UNF:FL_DNF]);
  assign push_rsp.result = mul_result;

  for (genvar i = 0; i < N_REQ; i++) begin : g_fifo
    assign push[i] = vld_pipe_q[LAT] && (id_pipe_q[LAT] == IW'(i));
    fpmul_rsp_fifo #(.DEPTH(DEPTH), .W(RSP_W)) u_fifo (
      .clk       (clk),
      .rst_n     (rst),
      .push      (push[i]),
      .push_data (push_rsp),
      .pop       (pop[i]),
      .rd_data   (rsp_q[i]),
      .empty     (empty[i]),
      .full      (full[i])
    );
    assign rsp_valid[i]    = !empty[i];
    assign rsp_result_v[i] = rsp_q[i].result;
    assign rsp_flags_v[i]  = rsp_q[i].flags;
  end

  assign rsp_result = rsp_result_v;
  assign rsp_flags  = rsp_flags_v;
  assign busy       = (|vld_pipe_q) || !(&empty);

`ifdef FPMUL_SEQ_PERF_EN
  logic [31:0] perf_issue_q, perf_issue_d, perf_stall_q, perf_stall_d;

  // Handshake and stall counters, free-running with wrap
  always_comb begin
    perf_issue_d = perf_issue_q + {31'd0, |req_ready};
    perf_stall_d = perf_stall_q + {31'd0, (|req_valid) && !(|req_ready)};
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_issue_q <= perf_issue_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_issue = perf_issue_q;
  assign perf_stall = perf_stall_q;
`endif
endmodule
